// File: rtl/interconnect_pkg.sv
// Shared types and channel-tag helpers for the inter-FPGA link arbiter.
package interconnect_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Next channel after ch, wrapping at n (round-robin pointer advance).
  function automatic int unsigned next_ch(input int unsigned ch, input int unsigned n);
    return (ch + 1 >= n) ? 0 : ch + 1;
  endfunction

  // A received tag addresses a real channel only when it is below n.
  function automatic bit tag_in_range(input int unsigned id, input int unsigned n);
    return id < n;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
module rr_priority_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan offsets from far to near so the nearest request to ptr wins.
  always_comb begin
    idx = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    end
  end

endmodule

// File: rtl/channel_link_arbiter.sv
// Shares one inter-FPGA link between CHANNELS logical channels.
// TX: round-robin with burst lock, tagged beat registered onto the link.
// RX: tagged beats demultiplexed back to per-channel streams (combinational).
// Optional: define LINK_ARB_STATS_EN to add per-channel saturating grant_count.
module channel_link_arbiter
  import interconnect_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH*CHANNELS-1:0]    tx_data,
  input  logic [CHANNELS-1:0]          tx_valid,
  output logic [CHANNELS-1:0]          tx_ready,
  output logic [WIDTH+ID_W-1:0]        link_out_data,
  output logic                         link_out_valid,
  input  logic                         link_out_ready,
  input  logic [WIDTH+ID_W-1:0]        link_in_data,
  input  logic                         link_in_valid,
  output logic                         link_in_ready,
  output logic [WIDTH*CHANNELS-1:0]    rx_data,
  output logic [CHANNELS-1:0]          rx_valid,
  input  logic [CHANNELS-1:0]          rx_ready,
  output logic                         link_busy
`ifdef LINK_ARB_STATS_EN
  ,
  output logic [16*CHANNELS-1:0]       grant_count
`endif
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t        state;
  logic [ID_W-1:0]   grant, rr_ptr, sel_idx, grant_nxt;
  logic              sel_any;
  logic [CNT_W-1:0]  burst_cnt;
  logic              load_en, accept, burst_last;
  logic [WIDTH-1:0]  tx_pay;
  logic [ID_W-1:0]   rx_id;
  logic [CHANNELS-1:0] rx_hit;

  rr_priority_select #(.N(CHANNELS), .IW(ID_W)) u_rr (
    .req (tx_valid),
    .ptr (rr_ptr),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Output slot is free when empty or draining this cycle.
  assign load_en    = !link_out_valid || link_out_ready;
  assign accept     = (state == BURST) && tx_valid[grant] && load_en;
  assign burst_last = burst_cnt == CNT_W'(MAX_BURST - 1);
  assign tx_pay     = tx_data[32'(grant)*WIDTH +: WIDTH];
  assign grant_nxt  = ID_W'(next_ch(32'(grant), CHANNELS));

  // Ready is offered to the granted channel regardless of its valid.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_tx
    assign tx_ready[c] = (state == BURST) && (grant == ID_W'(c)) && load_en;
  end

  // Arbitration FSM: IDLE picks a channel (bubble cycle), BURST streams it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant     <= sel_idx;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (burst_last) begin
              state  <= IDLE;
              rr_ptr <= grant_nxt;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else if (!tx_valid[grant] && load_en) begin
            // Requester went away with the link free: release the grant.
            state  <= IDLE;
            rr_ptr <= grant_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Link output register and registered busy status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      link_out_valid <= 1'b0;
      link_out_data  <= '0;
      link_busy      <= 1'b0;
    end else begin
      if (accept) begin
        link_out_data  <= {grant, tx_pay};
        link_out_valid <= 1'b1;
      end else if (link_out_ready) begin
        link_out_valid <= 1'b0;
      end
      link_busy <= (|tx_valid) || link_out_valid || link_in_valid;
    end
  end

  // RX demux: payload broadcast, valid steered by tag; bad tags are sunk.
  assign rx_id = link_in_data[WIDTH +: ID_W];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_rx
    assign rx_hit[c]                 = rx_id == ID_W'(c);
    assign rx_valid[c]               = link_in_valid && rx_hit[c];
    assign rx_data[c*WIDTH +: WIDTH] = link_in_data[WIDTH-1:0];
  end
  assign link_in_ready = !tag_in_range(32'(rx_id), CHANNELS) || (|(rx_ready & rx_hit));

`ifdef LINK_ARB_STATS_EN
  logic [CHANNELS-1:0][15:0] gcnt;

  // Per-channel accepted-beat counters, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (accept && grant == ID_W'(c) && gcnt[c] != 16'hFFFF) gcnt[c] <= gcnt[c] + 16'd1;
      end
    end
  end

  assign grant_count = gcnt;
`else
  // Default build carries no statistics counters.
`endif

endmodule
